pwm_core: RTL and testbench

Duty-cycle PWM generator that sits directly downstream of the 100 kHz divider stage. It consumes the divider's square-wave output as a step strobe and advances a period counter on each rising edge. It compares the count against a double-buffered duty value, expressed in steps of 1/(TOP+1), and produces the PWM output. Duty updates arrive through a valid/ready handshake and take effect only at a period boundary, so no output period is ever glitched.

---
 rtl/pwm_core.sv | 104 ++++++++++
 tb/tb_pwm_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_core.sv
// Purpose: duty-cycle PWM driven by the rising edges of a divider square wave, with double-buffered duty.
// Latency: one clk from tick_in first sampled high to cnt/pwm_out/period_start updating together.
// Backpressure: duty_ready = ~pending; one duty value is held until the next wrap (or en low) transfers it.
module pwm_core #(
   parameter int TOP = 99,
   parameter int W   = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_in,
   input  logic         en,
   input  logic [W-1:0] duty_in,
   input  logic         duty_valid,
   output logic         duty_ready,
   output logic         pwm_out,
   output logic         period_start
);

   // Duty fields carry one extra bit so TOP+1 (always-on) is representable even when TOP = 2^W-1.
   localparam int            DW        = W + 1;
   localparam logic [W-1:0]  CNT_TOP   = W'(TOP);
   localparam logic [DW-1:0] DUTY_FULL = DW'(TOP + 1);

   logic          tick_d;
   logic [W-1:0]  cnt;
   logic [W-1:0]  cnt_next;
   logic [DW-1:0] duty_shadow;
   logic [DW-1:0] duty_shadow_next;
   logic [DW-1:0] duty_active;
   logic [DW-1:0] duty_active_next;
   logic [DW-1:0] duty_clamped;
   logic          pending;
   logic          pending_next;
   logic          step;
   logic          wrap;
   logic          accept;
   logic          transfer;
   logic          pwm_next;

   assign duty_ready = ~pending;

   // Step strobe, wrap detect and the handshake/transfer events for this cycle.
   always_comb begin
      step     = tick_in & ~tick_d & en;
      wrap     = step & (cnt == CNT_TOP);
      accept   = duty_valid & ~pending;
      transfer = pending & (wrap | ~en);
   end

   // Period counter: held at 0 while disabled, advances on each step, wraps after TOP.
   always_comb begin
      cnt_next = cnt;
      if (!en) begin
         cnt_next = '0;
      end else if (step) begin
         cnt_next = wrap ? '0 : cnt + W'(1);
      end
   end

   // Duty double buffer: clamp and capture into the shadow, move to active only at a boundary.
   // Accept and transfer are mutually exclusive (pending gates both), so a value captured on
   // a wrap cycle waits for the following wrap.
   always_comb begin
      duty_clamped     = ({1'b0, duty_in} > DUTY_FULL) ? DUTY_FULL : {1'b0, duty_in};
      duty_shadow_next = duty_shadow;
      duty_active_next = duty_active;
      pending_next     = pending;
      if (accept) begin
         duty_shadow_next = duty_clamped;
         pending_next     = 1'b1;
      end
      if (transfer) begin
         duty_active_next = duty_shadow;
         pending_next     = 1'b0;
      end
   end

   // Output compare uses next-state values so a new duty appears on the same edge as its wrap.
   always_comb begin
      pwm_next = ({1'b0, cnt_next} < duty_active_next) & en;
   end

   // State registers, all cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_d       <= 1'b0;
         cnt          <= '0;
         duty_shadow  <= '0;
         duty_active  <= '0;
         pending      <= 1'b0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         tick_d       <= tick_in;
         cnt          <= cnt_next;
         duty_shadow  <= duty_shadow_next;
         duty_active  <= duty_active_next;
         pending      <= pending_next;
         pwm_out      <= pwm_next;
         period_start <= wrap;
      end
   end

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: tick_in toggles every 2 clk (one step per 4 clk, 400 clk per period).
// Expected per-period high times are queued as duty values are loaded and popped at each period_start.
// Handshake, enable gating and reset behaviour are checked at directed points.
module tb_pwm_core;

   localparam int TOP    = 99;
   localparam int W      = 7;
   localparam int SPS    = 4;               // clk cycles per step
   localparam int PERIOD = (TOP + 1) * SPS; // clk cycles per PWM period

   logic         clk;
   logic         rst;
   logic         tick_in;
   logic         en;
   logic [W-1:0] duty_in;
   logic         duty_valid;
   logic         duty_ready;
   logic         pwm_out;
   logic         period_start;

   pwm_core #(.TOP(TOP), .W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .tick_in      (tick_in),
      .en           (en),
      .duty_in      (duty_in),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks    = 0;
   int         failures  = 0;
   int         sb[$];          // expected high steps of upcoming complete periods
   int         hi_cnt    = 0;
   int         len_cnt   = 0;
   int         last_hi   = 0;
   bit         in_period = 1'b0;
   logic [1:0] ph        = 2'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_range(input string tag, input int got, input int lo, input int hi);
      checks++;
      assert (((got >= lo) && (got <= hi)) === 1'b1) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, got, lo, hi);
      end
   endtask

   // One clk cycle: sample after the edge, run the period scoreboard, then advance the tick phase.
   task automatic cyc();
      int e;
      @(posedge clk);
      #1;
      if (!rst || !en) begin
         in_period = 1'b0;
         hi_cnt    = 0;
         len_cnt   = 0;
      end else if (period_start) begin
         if (in_period && sb.size() > 0) begin
            e = sb.pop_front();
            chk("period_high_clk", hi_cnt, e * SPS);
            chk("period_len_clk", len_cnt, PERIOD);
         end
         last_hi   = hi_cnt;
         in_period = 1'b1;
         hi_cnt    = int'(pwm_out);
         len_cnt   = 1;
      end else begin
         hi_cnt  = hi_cnt + int'(pwm_out);
         len_cnt = len_cnt + 1;
      end
      ph      = ph + 2'd1;
      tick_in = ph[1];
   endtask

   task automatic load(input int d);
      duty_in    = W'(d);
      duty_valid = 1'b1;
      chk("ready_before_load", duty_ready, 1);
      cyc();
      duty_valid = 1'b0;
      chk("ready_drop_after_accept", duty_ready, 0);
   endtask

   task automatic wait_ps(input int bound, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!period_start && n < bound);
      chk("period_start_seen", period_start, 1);
   endtask

   task automatic wait_len(input int target, input int bound);
      int n = 0;
      while (len_cnt < target && n < bound) begin
         cyc();
         n++;
      end
      chk("reached_step_point", len_cnt, target);
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (sb.size() > 0 && n < bound) begin
         cyc();
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      int n;
      rst        = 1'b0;
      en         = 1'b1;
      tick_in    = 1'b0;
      duty_in    = '0;
      duty_valid = 1'b0;

      // Reset held with en high and tick toggling: outputs stay at reset values.
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk("rst_pwm_out", pwm_out, 0);
         chk("rst_period_start", period_start, 0);
         chk("rst_duty_ready", duty_ready, 1);
      end

      // Release mid-sequence; first wrap comes 100 steps later, which transfers duty 25.
      rst = 1'b1;
      load(25);
      wait_ps(PERIOD + 200, n);
      chk_range("first_wrap_after_release_clk", n + 1, PERIOD - 4, PERIOD + 4);
      chk("ready_after_first_wrap", duty_ready, 1);
      sb.push_back(25); sb.push_back(25);
      drain(3 * PERIOD);

      // Extremes: 0 never high, 100 always high, 120 clamps to 100.
      load(0);
      sb.push_back(25); sb.push_back(0); sb.push_back(0);
      drain(4 * PERIOD);
      load(100);
      sb.push_back(0); sb.push_back(100); sb.push_back(100);
      drain(4 * PERIOD);
      chk("full_duty_high_at_wrap", pwm_out, 1);
      load(120);
      sb.push_back(100); sb.push_back(100); sb.push_back(100);
      drain(4 * PERIOD);

      // Double buffering at duty 50: load 10 at step 30, a second request while pending is ignored.
      load(50);
      sb.push_back(100); sb.push_back(50);
      drain(3 * PERIOD);
      wait_len(30 * SPS, PERIOD);
      load(10);
      sb.push_back(50); sb.push_back(10); sb.push_back(10);
      duty_in    = W'(77);
      duty_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("ready_low_while_pending", duty_ready, 0);
      end
      duty_valid = 1'b0;
      wait_ps(PERIOD, n);
      chk("ready_return_after_wrap", duty_ready, 1);
      drain(3 * PERIOD);

      // Handshake on the exact wrap cycle: 60 waits one more period.
      wait_len(PERIOD, PERIOD + 10);
      sb.push_back(10); sb.push_back(10); sb.push_back(60);
      duty_in    = W'(60);
      duty_valid = 1'b1;
      chk("ready_before_wrap_load", duty_ready, 1);
      cyc();
      duty_valid = 1'b0;
      chk("wrap_cycle_period_start", period_start, 1);
      chk("ready_drop_wrap_load", duty_ready, 0);
      drain(3 * PERIOD);

      // Enable gating at step 40 with 20 pending: immediate transfer, fresh period on re-enable.
      wait_len(40 * SPS, PERIOD);
      load(20);
      en = 1'b0;
      cyc();
      chk("en_low_pwm_out", pwm_out, 0);
      chk("en_low_period_start", period_start, 0);
      chk("en_low_transfer_ready", duty_ready, 1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("en_low_hold_pwm_out", pwm_out, 0);
      end
      en = 1'b1;
      cyc();
      chk("first_en_cycle_pwm_out", pwm_out, 1);
      wait_ps(PERIOD + 200, n);
      chk_range("first_wrap_after_en_clk", n + 1, PERIOD - 4, PERIOD + 4);
      chk_range("restart_period_high_clk", last_hi, 20 * SPS - 5, 20 * SPS + 1);
      sb.push_back(20); sb.push_back(20);
      drain(3 * PERIOD);

      // Reset mid-period discards a pending duty.
      wait_len(25 * SPS, PERIOD);
      load(90);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_pwm_out", pwm_out, 0);
      chk("async_rst_duty_ready", duty_ready, 1);
      chk("async_rst_period_start", period_start, 0);
      cyc();
      cyc();
      rst = 1'b1;
      wait_ps(PERIOD + 200, n);
      sb.push_back(0);
      drain(2 * PERIOD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
